// File: rtl/tile_pixel_gen_if.sv
// Game-logic side bus of the tile pixel generator: host cell access, palette writes, clear engine.
// Latency: host reads return one clk after the strobe; palette writes land the next clk.
// Backpressure: none; host strobes are dropped while clr_busy is high.
//
// Signals: host_addr/host_wr/host_rd/host_wdata -> cell write/read request ({row, col} address)
//          host_rdata/host_rvalid                 <- read data and its one-cycle qualifier
//          pal_wr/pal_addr/pal_data               -> palette entry write (RGB332)
//          clr_start/clr_value                    -> whole-map fill request
//          clr_busy                               <- fill in progress
interface tile_pixel_gen_if #(
  parameter int COLS_BITS = 6,
  parameter int ROWS_BITS = 6,
  parameter int CELL_W    = 4
);
  logic [COLS_BITS+ROWS_BITS-1:0] host_addr;
  logic                           host_wr;
  logic                           host_rd;
  logic [CELL_W-1:0]              host_wdata;
  logic [CELL_W-1:0]              host_rdata;
  logic                           host_rvalid;
  logic                           pal_wr;
  logic [CELL_W-1:0]              pal_addr;
  logic [7:0]                     pal_data;
  logic                           clr_start;
  logic [CELL_W-1:0]              clr_value;
  logic                           clr_busy;

  // Game logic drives requests
  modport master (
    output host_addr, host_wr, host_rd, host_wdata,
    output pal_wr, pal_addr, pal_data,
    output clr_start, clr_value,
    input  host_rdata, host_rvalid, clr_busy
  );

  // Pixel generator serves them
  modport slave (
    input  host_addr, host_wr, host_rd, host_wdata,
    input  pal_wr, pal_addr, pal_data,
    input  clr_start, clr_value,
    output host_rdata, host_rvalid, clr_busy
  );
endinterface

// File: rtl/tile_pixel_gen.sv
// Tile-map pixel generator: raster position -> tile RAM cell -> palette -> RGB332, with grid overlay and clear engine.
// Latency: 3 clk from pixel_x/pixel_y/video_on to out_*; host read data 1 clk after an accepted host_rd.
// Backpressure: none; video runs every clk, host strobes are ignored while a clear runs.
//
// Ports: clk, rst_n             pixel clock, async active-low reset
//        video_on, pixel_x/y    raster input from the sync generator
//        grid_en                draw tile-edge grid lines in GRID_COLOR
//        host (slave modport)   host cell port, palette writes, clear engine control/status
//        out_red/green/blue     registered RGB332 colour
module tile_pixel_gen #(
  parameter int         TILE_SHIFT = 4,
  parameter int         COLS_BITS  = 6,
  parameter int         ROWS_BITS  = 6,
  parameter int         CELL_W     = 4,
  parameter logic [7:0] GRID_COLOR = 8'h49
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             video_on,
  input  logic [9:0]       pixel_x,
  input  logic [9:0]       pixel_y,
  input  logic             grid_en,
  tile_pixel_gen_if.slave  host,
  output logic [2:0]       out_red,
  output logic [2:0]       out_green,
  output logic [1:0]       out_blue
);

  localparam int ADDR_W = COLS_BITS + ROWS_BITS;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int PAL_N  = 1 << CELL_W;

  // Bits of the shifted coordinate that are allowed to be set; anything
  // outside these masks means the tile index overflows its field.
  localparam logic [9:0] COL_MASK = 10'((32'd1 << COLS_BITS) - 32'd1);
  localparam logic [9:0] ROW_MASK = 10'((32'd1 << ROWS_BITS) - 32'd1);

  typedef struct packed {
    logic von;
    logic in_range;
    logic grid;
  } vflags_t;

  typedef enum logic {IDLE, CLEAR} clr_state_t;

  // Power-on palette: index widened to 4 bits and spread across R, G and B.
  function automatic logic [7:0] legacy_color(input int k);
    logic [3:0] i;
    i = 4'(k);
    return {i[2:0], i[3:1], i[1:0]};
  endfunction

  logic [CELL_W-1:0] tile_ram [DEPTH];
  logic [7:0]        palette  [PAL_N];

  // ---------------- video address and flags ----------------
  logic [9:0]        col_full;
  logic [9:0]        row_full;
  logic              in_range;
  logic              on_line;
  logic [ADDR_W-1:0] vaddr;

  assign col_full = pixel_x >> TILE_SHIFT;
  assign row_full = pixel_y >> TILE_SHIFT;
  assign in_range = ((col_full & ~COL_MASK) == '0) && ((row_full & ~ROW_MASK) == '0);
  assign on_line  = grid_en && ((pixel_x[TILE_SHIFT-1:0] == '0) || (pixel_y[TILE_SHIFT-1:0] == '0));
  assign vaddr    = {row_full[ROWS_BITS-1:0], col_full[COLS_BITS-1:0]};

  // ---------------- clear engine ----------------
  clr_state_t        state;
  logic              busy_q;
  logic [ADDR_W-1:0] clr_addr;
  logic [CELL_W-1:0] clr_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      clr_addr <= '0;
      clr_val  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (host.clr_start) begin
            state    <= CLEAR;
            busy_q   <= 1'b1;
            clr_addr <= '0;
            clr_val  <= host.clr_value;
          end
        end
        CLEAR: begin
          if (clr_addr == '1) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign host.clr_busy = busy_q;

  // ---------------- port B: clear engine owns it while busy ----------------
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [CELL_W-1:0] b_wdata;
  logic              rd_accept;

  always_comb begin
    b_we    = 1'b0;
    b_addr  = host.host_addr;
    b_wdata = host.host_wdata;
    if (state == CLEAR) begin
      b_we    = 1'b1;
      b_addr  = clr_addr;
      b_wdata = clr_val;
    end else begin
      b_we = host.host_wr;
    end
  end

  // A write in the same cycle wins over a read; the read is simply dropped.
  assign rd_accept = host.host_rd && !host.host_wr && (state == IDLE);

  // ---------------- tile RAM (contents not reset) ----------------
  logic [CELL_W-1:0] vcell_q;
  logic [CELL_W-1:0] rdata_q;

  // Non-blocking reads see pre-write contents, giving read-first behaviour
  // on both ports when video and host hit the same cell.
  always_ff @(posedge clk) begin
    if (b_we) tile_ram[b_addr] <= b_wdata;
    if (rd_accept) rdata_q <= tile_ram[b_addr];
    vcell_q <= tile_ram[vaddr];
  end

  logic rvalid_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rvalid_q <= 1'b0;
    else        rvalid_q <= rd_accept;
  end

  assign host.host_rdata  = rdata_q;
  assign host.host_rvalid = rvalid_q;

  // ---------------- palette ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PAL_N; k++) palette[k] <= legacy_color(k);
    end else if (host.pal_wr) begin
      palette[host.pal_addr] <= host.pal_data;
    end
  end

  // ---------------- video pipeline ----------------
  vflags_t    s1;
  vflags_t    s2;
  logic [7:0] pal_q;
  logic [7:0] rgb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      pal_q <= '0;
      rgb_q <= '0;
    end else begin
      // stage 1: RAM read happens alongside (vcell_q)
      s1.von      <= video_on;
      s1.in_range <= in_range;
      s1.grid     <= in_range && on_line;
      // stage 2: palette lookup
      s2    <= s1;
      pal_q <= palette[vcell_q];
      // stage 3: output priority mux
      if (!s2.von || !s2.in_range) rgb_q <= '0;
      else if (s2.grid)            rgb_q <= GRID_COLOR;
      else                         rgb_q <= pal_q;
    end
  end

  assign out_red   = rgb_q[7:5];
  assign out_green = rgb_q[4:2];
  assign out_blue  = rgb_q[1:0];

endmodule

// File: tb/tb_tile_pixel_gen.sv
module tb_tile_pixel_gen;
  localparam int CB = 5;
  localparam int RB = 7;
  localparam int CW = 4;
  localparam int AW = CB + RB;

  logic          clk;
  logic          rst_n;
  logic          video_on;
  logic          grid_en;
  logic [9:0]    pixel_x;
  logic [9:0]    pixel_y;
  logic [2:0]    out_red;
  logic [2:0]    out_green;
  logic [1:0]    out_blue;

  tile_pixel_gen_if #(.COLS_BITS(CB), .ROWS_BITS(RB), .CELL_W(CW)) hif();

  tile_pixel_gen #(
    .TILE_SHIFT(4), .COLS_BITS(CB), .ROWS_BITS(RB), .CELL_W(CW), .GRID_COLOR(8'h49)
  ) dut (
    .clk(clk), .rst_n(rst_n), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .grid_en(grid_en), .host(hif.slave),
    .out_red(out_red), .out_green(out_green), .out_blue(out_blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]    vid_q [$];
  logic [CW-1:0] rd_q  [$];

  // Marks the cycle a checked pixel is presented; the monitor compares the
  // colour when this marker has travelled through three clock edges.
  logic chk = 1'b0;
  logic chk_d1 = 1'b0;
  logic chk_d2 = 1'b0;
  logic chk_d3 = 1'b0;

  always @(posedge clk) begin
    chk_d1 <= chk;
    chk_d2 <= chk_d1;
    chk_d3 <= chk_d2;
  end

  logic [7:0]    vexp;
  logic [CW-1:0] rexp;

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (chk_d3) begin
      checks++;
      if (vid_q.size() == 0) begin
        errors++;
        $display("FAIL video_unexpected: colour %h appeared with nothing expected", {out_red, out_green, out_blue});
      end else begin
        vexp = vid_q.pop_front();
        if ({out_red, out_green, out_blue} !== vexp) begin
          errors++;
          $display("FAIL video_color: got %h required %h", {out_red, out_green, out_blue}, vexp);
        end
      end
    end
    if (hif.host_rvalid === 1'b1) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected: rvalid with rdata %h, no read expected", hif.host_rdata);
      end else begin
        rexp = rd_q.pop_front();
        if (hif.host_rdata !== rexp) begin
          errors++;
          $display("FAIL host_rdata: got %h required %h", hif.host_rdata, rexp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic von, input logic [7:0] exp);
    pixel_x  = x;
    pixel_y  = y;
    video_on = von;
    chk      = 1'b1;
    vid_q.push_back(exp);
    tick();
    chk = 1'b0;
  endtask

  task automatic hwr(input logic [AW-1:0] addr, input logic [CW-1:0] data);
    hif.host_addr  = addr;
    hif.host_wdata = data;
    hif.host_wr    = 1'b1;
    tick();
    hif.host_wr = 1'b0;
  endtask

  task automatic hrd(input logic [AW-1:0] addr, input logic [CW-1:0] exp);
    hif.host_addr = addr;
    hif.host_rd   = 1'b1;
    rd_q.push_back(exp);
    tick();
    hif.host_rd = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  int cnt;

  initial begin
    rst_n = 1'b0;
    video_on = 1'b0; grid_en = 1'b0; pixel_x = '0; pixel_y = '0;
    hif.host_addr = '0; hif.host_wr = 1'b0; hif.host_rd = 1'b0; hif.host_wdata = '0;
    hif.pal_wr = 1'b0; hif.pal_addr = '0; hif.pal_data = '0;
    hif.clr_start = 1'b0; hif.clr_value = '0;
    repeat (3) tick();

    // Reset state
    check("reset_color", {24'd0, out_red, out_green, out_blue}, 32'h0);
    check("reset_rvalid", {31'd0, hif.host_rvalid}, 32'h0);
    check("reset_busy", {31'd0, hif.clr_busy}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Default palette: code 5 -> {101,010,01}
    hwr(12'h000, 4'h5);
    pix(10'd0, 10'd0, 1'b1, 8'hA9);

    // Palette rewrite, then blanking
    hif.pal_addr = 4'd5; hif.pal_data = 8'hE0; hif.pal_wr = 1'b1;
    tick();
    hif.pal_wr = 1'b0;
    pix(10'd0, 10'd0, 1'b1, 8'hE0);
    pix(10'd0, 10'd0, 1'b0, 8'h00);

    // Grid and range; cell (row 1, col 1) = addr 33 holds code 3 -> 8'h67
    hwr(12'd33, 4'h3);
    grid_en = 1'b1;
    pix(10'd16,   10'd20, 1'b1, 8'h49);
    pix(10'd17,   10'd20, 1'b1, 8'h67);
    pix(10'd17,   10'd16, 1'b1, 8'h49);
    pix(10'd0,    10'd0,  1'b1, 8'h49);
    pix(10'd1023, 10'd20, 1'b1, 8'h00);
    grid_en = 1'b0;
    pix(10'd16,   10'd20, 1'b1, 8'h67);
    pix(10'd1023, 10'd0,  1'b1, 8'h00);
    pix(10'd16,   10'd20, 1'b0, 8'h00);

    // Host write/read, simultaneous wr+rd
    hwr(12'h123, 4'hA);
    hrd(12'h123, 4'hA);
    hif.host_addr = 12'h124; hif.host_wdata = 4'h6;
    hif.host_wr = 1'b1; hif.host_rd = 1'b1;
    tick();
    hif.host_wr = 1'b0; hif.host_rd = 1'b0;
    check("wr_rd_no_rvalid", {31'd0, hif.host_rvalid}, 32'h0);
    hrd(12'h124, 4'h6);
    tick();
    check("rvalid_single_pulse", {31'd0, hif.host_rvalid}, 32'h0);
    check("rdata_hold", {28'd0, hif.host_rdata}, 32'h6);

    // Clear engine with host access and restart attempts while busy
    hif.clr_value = 4'h3; hif.clr_start = 1'b1;
    tick();
    hif.clr_start = 1'b0;
    check("clr_busy_rise", {31'd0, hif.clr_busy}, 32'h1);
    cnt = 0;
    while (hif.clr_busy === 1'b1 && cnt < 5000) begin
      hif.host_wr = 1'b0; hif.host_rd = 1'b0; hif.clr_start = 1'b0;
      if (cnt == 100) begin
        hif.host_addr = 12'd10; hif.host_wdata = 4'hF; hif.host_wr = 1'b1;
      end else if (cnt == 150) begin
        hif.host_addr = 12'd10; hif.host_rd = 1'b1;
      end else if (cnt == 200) begin
        hif.clr_value = 4'h7; hif.clr_start = 1'b1;
      end
      tick();
      cnt++;
    end
    hif.host_wr = 1'b0; hif.host_rd = 1'b0; hif.clr_start = 1'b0;
    check("clr_busy_cycles", cnt, 32'd4096);
    hrd(12'h000, 4'h3);
    hrd(12'h7FF, 4'h3);
    hrd(12'hFFF, 4'h3);
    hrd(12'd10,  4'h3);
    hrd(12'h123, 4'h3);

    // Reset in the middle of a clear
    hwr(12'd50,  4'h9);
    hwr(12'd200, 4'h9);
    hif.clr_value = 4'h5; hif.clr_start = 1'b1;
    tick();
    hif.clr_start = 1'b0;
    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    check("reset_abort_busy", {31'd0, hif.clr_busy}, 32'h0);
    check("reset_abort_color", {24'd0, out_red, out_green, out_blue}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    hrd(12'd50,  4'h5);
    hrd(12'd200, 4'h9);

    repeat (5) tick();
    check("queues_drained", vid_q.size() + rd_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
